// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word/field types plus fetch-stage state and reset constants.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;
    typedef logic [2:0]  lc3b_reg;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} if_state_t;

    localparam lc3b_word LC3B_PC_RESET = 16'h0000;
    localparam lc3b_word LC3B_NOP      = 16'h0000;

    // Instructions are word aligned, so byte-address bit 0 is forced low.
    function automatic lc3b_word pc_align(input lc3b_word a);
        return a & 16'hFFFE;
    endfunction

endpackage

// File: rtl/if_hold_buffer.sv
// if_hold_buffer: parks one fetched {ir, pc} pair while decode is stalled.
module if_hold_buffer
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load,
    input  logic     clear,
    input  lc3b_word ir_d,
    input  lc3b_word pc_d,
    output lc3b_word ir_q,
    output lc3b_word pc_q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q <= LC3B_NOP;
            pc_q <= '0;
        end else if (clear) begin
            ir_q <= LC3B_NOP;
            pc_q <= '0;
        end else if (load) begin
            ir_q <= ir_d;
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: LC-3b IF stage with stall hold buffer and branch redirect,
// keeping the request address stable until the memory responds.
module instruction_fetch
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = LC3B_PC_RESET
) (
    input  logic       clk,
    input  logic       reset,
    output lc3b_word   imem_address,
    output logic       imem_read,
    input  lc3b_word   imem_rdata,
    input  logic       imem_resp,
    input  logic       load_use_stall,
    input  logic       branch_taken,
    input  lc3b_word   branch_target,
    output logic       ifid_valid,
    output lc3b_word   ifid_ir,
    output lc3b_word   ifid_pc,
    output lc3b_opcode ifid_opcode,
    output lc3b_reg    ifid_dest,
    output lc3b_reg    ifid_src1,
    output lc3b_reg    ifid_src2
);

    if_state_t state;
    lc3b_word  pc;
    lc3b_word  target;
    lc3b_word  pc_inc;
    lc3b_word  hold_ir;
    lc3b_word  hold_pc;
    logic      hold_load;

    assign pc_inc       = pc + 16'd2;
    assign imem_address = pc;
    assign ifid_opcode  = ifid_ir[15:12];
    assign ifid_dest    = ifid_ir[11:9];
    assign ifid_src1    = ifid_ir[8:6];
    assign ifid_src2    = ifid_ir[2:0];
    assign hold_load    = state == FETCH && imem_resp && load_use_stall && !branch_taken;

    if_hold_buffer u_hold (
        .clk   (clk),
        .reset (reset),
        .load  (hold_load),
        .clear (branch_taken),
        .ir_d  (imem_rdata),
        .pc_d  (pc_inc),
        .ir_q  (hold_ir),
        .pc_q  (hold_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= pc_align(RESET_PC);
            target     <= '0;
            imem_read  <= 1'b0;
            ifid_valid <= 1'b0;
            ifid_ir    <= LC3B_NOP;
            ifid_pc    <= '0;
        end else if (branch_taken) begin
            ifid_valid <= 1'b0;
            ifid_ir    <= LC3B_NOP;
            imem_read  <= 1'b1;
            // An outstanding request must finish at its old address; park the target.
            if ((state == FETCH || state == DISCARD) && !imem_resp) begin
                state  <= DISCARD;
                target <= pc_align(branch_target);
            end else begin
                state <= FETCH;
                pc    <= pc_align(branch_target);
            end
        end else begin
            case (state)
                IDLE: begin
                    state     <= FETCH;
                    imem_read <= 1'b1;
                end
                FETCH: begin
                    if (imem_resp) begin
                        pc <= pc_inc;
                        if (load_use_stall) begin
                            state     <= HOLD;
                            imem_read <= 1'b0;
                        end else begin
                            ifid_valid <= 1'b1;
                            ifid_ir    <= imem_rdata;
                            ifid_pc    <= pc_inc;
                        end
                    end else if (!load_use_stall) begin
                        ifid_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!load_use_stall) begin
                        state      <= FETCH;
                        imem_read  <= 1'b1;
                        ifid_valid <= 1'b1;
                        ifid_ir    <= hold_ir;
                        ifid_pc    <= hold_pc;
                    end
                end
                DISCARD: begin
                    if (imem_resp) begin
                        state <= FETCH;
                        pc    <= target;
                    end
                end
                default: begin
                    state     <= IDLE;
                    imem_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector table plus async-reset sequence for instruction_fetch.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] imem_address;
    logic        imem_read;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic        load_use_stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        ifid_valid;
    logic [15:0] ifid_ir;
    logic [15:0] ifid_pc;
    logic [3:0]  ifid_opcode;
    logic [2:0]  ifid_dest;
    logic [2:0]  ifid_src1;
    logic [2:0]  ifid_src2;

    int total = 0;
    int bad = 0;

    instruction_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_address   (imem_address),
        .imem_read      (imem_read),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .load_use_stall (load_use_stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .ifid_valid     (ifid_valid),
        .ifid_ir        (ifid_ir),
        .ifid_pc        (ifid_pc),
        .ifid_opcode    (ifid_opcode),
        .ifid_dest      (ifid_dest),
        .ifid_src1      (ifid_src1),
        .ifid_src2      (ifid_src2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        resp;
        logic [15:0] rdata;
        logic        stall;
        logic        br;
        logic [15:0] bt;
        logic        e_read;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_ir;
        logic [15:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int row, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
        end
    endtask

    task automatic check_outputs(input int row, input logic e_read, input logic [15:0] e_addr,
                                 input logic e_valid, input logic [15:0] e_ir, input logic [15:0] e_pc);
        check("imem_read", row, {15'd0, imem_read}, {15'd0, e_read});
        check("imem_address", row, imem_address, e_addr);
        check("ifid_valid", row, {15'd0, ifid_valid}, {15'd0, e_valid});
        check("ifid_ir", row, ifid_ir, e_ir);
        check("ifid_pc", row, ifid_pc, e_pc);
    endtask

    initial begin
        // rst resp rdata stall br bt | read addr valid ir pc  (outputs after the edge)
        vecs.push_back(vec_t'{1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000});
        vecs.push_back(vec_t'{0, 1, 16'h1234, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000});
        vecs.push_back(vec_t'{0, 1, 16'h1234, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'h1234, 16'h0002});
        vecs.push_back(vec_t'{0, 1, 16'h1234, 0, 0, 16'h0000, 1, 16'h0004, 1, 16'h1234, 16'h0004});
        vecs.push_back(vec_t'{0, 1, 16'hABCD, 1, 0, 16'h0000, 0, 16'h0006, 1, 16'h1234, 16'h0004});
        vecs.push_back(vec_t'{0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0006, 1, 16'h1234, 16'h0004});
        vecs.push_back(vec_t'{0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0006, 1, 16'h1234, 16'h0004});
        vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0006, 1, 16'hABCD, 16'h0006});
        vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0006, 0, 16'hABCD, 16'h0006});
        vecs.push_back(vec_t'{0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0006, 0, 16'hABCD, 16'h0006});
        vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 1, 16'h3001, 1, 16'h0006, 0, 16'h0000, 16'h0006});
        vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0006, 0, 16'h0000, 16'h0006});
        vecs.push_back(vec_t'{0, 1, 16'hDEAD, 0, 0, 16'h0000, 1, 16'h3000, 0, 16'h0000, 16'h0006});
        vecs.push_back(vec_t'{0, 1, 16'h5555, 0, 0, 16'h0000, 1, 16'h3002, 1, 16'h5555, 16'h3002});
        vecs.push_back(vec_t'{0, 1, 16'h7777, 1, 1, 16'hFFFE, 1, 16'hFFFE, 0, 16'h0000, 16'h3002});
        vecs.push_back(vec_t'{0, 1, 16'h4321, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'h4321, 16'h0000});
        vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 1, 16'h0100, 1, 16'h0000, 0, 16'h0000, 16'h0000});
        vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 1, 16'h0200, 1, 16'h0000, 0, 16'h0000, 16'h0000});
        vecs.push_back(vec_t'{0, 1, 16'hBEEF, 0, 0, 16'h0000, 1, 16'h0200, 0, 16'h0000, 16'h0000});
        vecs.push_back(vec_t'{0, 1, 16'h1111, 0, 0, 16'h0000, 1, 16'h0202, 1, 16'h1111, 16'h0202});

        foreach (vecs[i]) begin
            reset          = vecs[i].rst;
            imem_resp      = vecs[i].resp;
            imem_rdata     = vecs[i].rdata;
            load_use_stall = vecs[i].stall;
            branch_taken   = vecs[i].br;
            branch_target  = vecs[i].bt;
            @(posedge clk);
            #1;
            check_outputs(i, vecs[i].e_read, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_ir, vecs[i].e_pc);
        end

        // Reset mid-request must take effect without a clock edge.
        @(negedge clk);
        imem_resp    = 1'b0;
        branch_taken = 1'b0;
        reset        = 1'b1;
        #1;
        check_outputs(100, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        check_outputs(101, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        // A stray response right after release is ignored while in IDLE.
        reset      = 1'b0;
        imem_resp  = 1'b1;
        imem_rdata = 16'h9999;
        @(posedge clk);
        #1;
        check_outputs(102, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        imem_rdata = 16'h2222;
        @(posedge clk);
        #1;
        check_outputs(103, 1'b1, 16'h0002, 1'b1, 16'h2222, 16'h0002);
        check("ifid_opcode", 103, {12'd0, ifid_opcode}, 16'd2);
        check("ifid_dest", 103, {13'd0, ifid_dest}, 16'd1);
        check("ifid_src1", 103, {13'd0, ifid_src1}, 16'd0);
        check("ifid_src2", 103, {13'd0, ifid_src2}, 16'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
